// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings used by the writeback stage: wb_sel codes, load funct3
// codes, the writeback FSM state type and the load legality rule.
package rv32i_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } wb_state_e;

    // A load is legal when funct3 names a real load and the address is naturally aligned.
    function automatic logic ld_legal(input logic [2:0] ld_type, input logic [1:0] offset);
        logic ok;
        case (ld_type)
            LD_LB, LD_LBU: ok = 1'b1;
            LD_LH, LD_LHU: ok = (offset[0] == 1'b0);
            LD_LW:         ok = (offset == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ld_ext.sv
// Combinational load extraction: picks the byte/half addressed by the offset out of
// the aligned memory word and sign- or zero-extends it to 32 bits.
module ld_ext
    import rv32i_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];
        result   = '0;
        case (ld_type)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'b0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'b0, half_sel};
            LD_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: registers ALU/PC+4 results into the register file in one
// cycle and holds a single outstanding load until data memory answers.
module wb_stage
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [4:0]  i_rd_5,
    input  logic        i_rd_wen,
    input  logic [1:0]  i_wb_sel_2,
    input  logic [31:0] i_alu_32,
    input  logic [31:0] i_pc_32,
    input  logic [2:0]  i_ld_type_3,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata_32,
    output logic        o_wen,
    output logic [4:0]  o_waddr_5,
    output logic [31:0] o_wdata_32,
    output logic        o_ld_pending,
    output logic [4:0]  o_ld_rd_5,
    output logic        o_ld_err,
    output logic [63:0] o_instret_64
);

    wb_state_e   state, state_nx;
    logic [2:0]  ld_type_q;
    logic [1:0]  ld_off_q;
    logic        ld_wen_q;
    logic [31:0] ld_data;

    logic        commit;
    logic        commit_wen;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic        ld_start;
    logic        ld_bad;

    assign o_ready = (state == IDLE);

    ld_ext u_ld_ext (
        .ld_type (ld_type_q),
        .offset  (ld_off_q),
        .word    (i_dmem_rdata_32),
        .result  (ld_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Writes to x0 or with rd_wen low still retire; only the port enable is suppressed.
    always_comb begin
        state_nx    = state;
        commit      = 1'b0;
        commit_wen  = 1'b0;
        commit_addr = '0;
        commit_data = '0;
        ld_start    = 1'b0;
        ld_bad      = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (i_wb_sel_2 == WB_SEL_LOAD) begin
                        if (ld_legal(i_ld_type_3, i_alu_32[1:0])) begin
                            state_nx = WAIT_LD;
                            ld_start = 1'b1;
                        end else begin
                            ld_bad = 1'b1;
                        end
                    end else begin
                        commit      = 1'b1;
                        commit_wen  = i_rd_wen && (i_rd_5 != 5'd0);
                        commit_addr = i_rd_5;
                        commit_data = (i_wb_sel_2 == WB_SEL_PC4) ? i_pc_32 + 32'd4 : i_alu_32;
                    end
                end
            end
            WAIT_LD: begin
                if (i_dmem_rvalid) begin
                    state_nx    = IDLE;
                    commit      = 1'b1;
                    commit_wen  = ld_wen_q && (o_ld_rd_5 != 5'd0);
                    commit_addr = o_ld_rd_5;
                    commit_data = ld_data;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_wen        <= 1'b0;
            o_waddr_5    <= '0;
            o_wdata_32   <= '0;
            o_ld_pending <= 1'b0;
            o_ld_rd_5    <= '0;
            o_ld_err     <= 1'b0;
            o_instret_64 <= '0;
            ld_type_q    <= '0;
            ld_off_q     <= '0;
            ld_wen_q     <= 1'b0;
        end else begin
            o_wen        <= commit_wen;
            o_waddr_5    <= commit_addr;
            o_wdata_32   <= commit_data;
            o_ld_err     <= ld_bad;
            o_ld_pending <= (state_nx == WAIT_LD);
            o_instret_64 <= o_instret_64 + 64'(commit);
            if (ld_start) begin
                o_ld_rd_5 <= i_rd_5;
                ld_type_q <= i_ld_type_3;
                ld_off_q  <= i_alu_32[1:0];
                ld_wen_q  <= i_rd_wen;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a driver issues directed and random instructions and
// queues expected commits; a monitor pops and compares whenever the stage retires or errors.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rd_5;
    logic        i_rd_wen;
    logic [1:0]  i_wb_sel_2;
    logic [31:0] i_alu_32;
    logic [31:0] i_pc_32;
    logic [2:0]  i_ld_type_3;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata_32;
    logic        o_wen;
    logic [4:0]  o_waddr_5;
    logic [31:0] o_wdata_32;
    logic        o_ld_pending;
    logic [4:0]  o_ld_rd_5;
    logic        o_ld_err;
    logic [63:0] o_instret_64;

    typedef struct {
        bit          err;
        bit          wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    wb_stage dut (
        .clk             (clk),
        .rstn            (rstn),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_rd_5          (i_rd_5),
        .i_rd_wen        (i_rd_wen),
        .i_wb_sel_2      (i_wb_sel_2),
        .i_alu_32        (i_alu_32),
        .i_pc_32         (i_pc_32),
        .i_ld_type_3     (i_ld_type_3),
        .i_dmem_rvalid   (i_dmem_rvalid),
        .i_dmem_rdata_32 (i_dmem_rdata_32),
        .o_wen           (o_wen),
        .o_waddr_5       (o_waddr_5),
        .o_wdata_32      (o_wdata_32),
        .o_ld_pending    (o_ld_pending),
        .o_ld_rd_5       (o_ld_rd_5),
        .o_ld_err        (o_ld_err),
        .o_instret_64    (o_instret_64)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input int t, input int off);
        if (t == 0 || t == 4) return 1'b1;
        if (t == 1 || t == 5) return (off % 2) == 0;
        if (t == 2) return off == 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input int t, input int off, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (t)
            0: return (b >= 128) ? b - 32'd256 : b;
            4: return b;
            1: return (h >= 32768) ? h - 32'd65536 : h;
            5: return h;
            default: return w;
        endcase
    endfunction

    // Issues one instruction and, for a legal load, plays data memory after lat cycles.
    task automatic applyStimulus(input logic [4:0] rd, input bit wen, input logic [1:0] sel,
                                 input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] t,
                                 input int lat, input logic [31:0] rdata, input bit abandon);
        bit   is_load;
        bit   legal;
        exp_t e;
        int   waited;
        is_load = (sel == 2'b01);
        legal   = ref_legal(int'(t), int'(alu[1:0]));
        waited  = 0;
        while (!o_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("ready_before_issue", 64'(o_ready), 64'd1);
        i_valid = 1'b1; i_rd_5 = rd; i_rd_wen = wen; i_wb_sel_2 = sel;
        i_alu_32 = alu; i_pc_32 = pc; i_ld_type_3 = t;
        i_dmem_rvalid = 1'($urandom_range(0, 1));
        i_dmem_rdata_32 = $urandom;
        @(posedge clk);
        e.err = 1'b0; e.wen = wen && (rd != 5'd0); e.addr = rd; e.data = alu;
        if (is_load && !legal) begin
            e.err = 1'b1; e.wen = 1'b0;
            sb.push_back(e);
        end else if (!is_load) begin
            e.data = (sel == 2'b10) ? pc + 32'd4 : alu;
            sb.push_back(e);
        end else if (!abandon) begin
            e.data = ref_load(int'(t), int'(alu[1:0]), rdata);
            sb.push_back(e);
        end
        #1;
        i_valid = 1'b0;
        i_dmem_rvalid = 1'b0;
        if (is_load && legal) begin
            checkOutput("ready_low_in_wait", 64'(o_ready), 64'd0);
            checkOutput("ld_pending_set", 64'(o_ld_pending), 64'd1);
            checkOutput("ld_rd", 64'(o_ld_rd_5), 64'(rd));
            if (!abandon) begin
                for (int k = 1; k < lat; k++) begin
                    i_valid = 1'b1; i_rd_5 = 5'($urandom); i_rd_wen = 1'b1;
                    i_wb_sel_2 = 2'b00; i_alu_32 = $urandom;
                    @(posedge clk); #1;
                    checkOutput("ready_held_low", 64'(o_ready), 64'd0);
                end
                i_valid = 1'b1;
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata_32 = rdata;
                @(posedge clk); #1;
                i_valid = 1'b0;
                i_dmem_rvalid = 1'b0;
                checkOutput("ld_pending_clear", 64'(o_ld_pending), 64'd0);
                checkOutput("ready_after_load", 64'(o_ready), 64'd1);
            end
        end
    endtask

    // Monitor: any write, error pulse or retirement must match the oldest expectation.
    initial begin
        exp_t        e;
        logic [63:0] exp_instret;
        logic [63:0] prev_instret;
        exp_instret  = '0;
        prev_instret = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_instret  = '0;
                prev_instret = '0;
            end else if (o_wen || o_ld_err || (o_instret_64 != prev_instret)) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_event", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("ld_err", 64'(o_ld_err), 64'(e.err));
                    checkOutput("wen", 64'(o_wen), 64'(e.wen));
                    if (e.wen) begin
                        checkOutput("waddr", 64'(o_waddr_5), 64'(e.addr));
                        checkOutput("wdata", 64'(o_wdata_32), 64'(e.data));
                    end
                    if (!e.err) exp_instret = exp_instret + 64'd1;
                    checkOutput("instret", o_instret_64, exp_instret);
                end
                prev_instret = o_instret_64;
            end
        end
    end

    initial begin
        int waited;
        rstn = 1'b0; i_valid = 1'b0; i_rd_5 = '0; i_rd_wen = 1'b0; i_wb_sel_2 = '0;
        i_alu_32 = '0; i_pc_32 = '0; i_ld_type_3 = '0; i_dmem_rvalid = 1'b0; i_dmem_rdata_32 = '0;
        #12;
        checkOutput("reset_wen", 64'(o_wen), 64'd0);
        checkOutput("reset_pending", 64'(o_ld_pending), 64'd0);
        checkOutput("reset_instret", o_instret_64, 64'd0);
        checkOutput("reset_ready", 64'(o_ready), 64'd1);
        @(posedge clk); #1; rstn = 1'b1;
        @(posedge clk); #1;

        applyStimulus(5'd5, 1'b1, 2'b00, 32'h1234_5678, 32'h100, 3'd0, 1, 32'h0, 1'b0);
        applyStimulus(5'd3, 1'b1, 2'b01, 32'h0000_1002, 32'h104, 3'b000, 3, 32'h0080_0000, 1'b0);
        applyStimulus(5'd7, 1'b1, 2'b01, 32'h0000_2002, 32'h108, 3'b101, 2, 32'hBEEF_0000, 1'b0);
        applyStimulus(5'd8, 1'b1, 2'b01, 32'h0000_3001, 32'h10C, 3'b010, 1, 32'h0, 1'b0);
        applyStimulus(5'd9, 1'b1, 2'b01, 32'h0000_3000, 32'h110, 3'b110, 1, 32'h0, 1'b0);
        applyStimulus(5'd1, 1'b1, 2'b10, 32'h0, 32'hFFFF_FFFC, 3'd0, 1, 32'h0, 1'b0);
        applyStimulus(5'd0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'h114, 3'd0, 1, 32'h0, 1'b0);
        applyStimulus(5'd6, 1'b0, 2'b11, 32'hCAFE_0000, 32'h118, 3'd0, 1, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)
            applyStimulus(5'(10 + i), 1'b1, 2'b00, 32'hA000_0000 + 32'(i), 32'h200, 3'd0, 1, 32'h0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            logic [1:0]  sel;
            logic [2:0]  t;
            sel = 2'($urandom_range(0, 3));
            t   = 3'($urandom_range(0, 7));
            applyStimulus(5'($urandom), 1'($urandom_range(0, 3) != 0), sel, $urandom, $urandom,
                          t, int'($urandom_range(1, 4)), $urandom, 1'b0);
        end

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);

        applyStimulus(5'd4, 1'b1, 2'b01, 32'h0000_0000, 32'h300, 3'b010, 1, 32'h0, 1'b1);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        checkOutput("midload_reset_pending", 64'(o_ld_pending), 64'd0);
        checkOutput("midload_reset_instret", o_instret_64, 64'd0);
        checkOutput("midload_reset_ready", 64'(o_ready), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b1;
        checkOutput("ready_after_release", 64'(o_ready), 64'd1);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata_32 = 32'h1234_5678;
        @(posedge clk); #1;
        i_dmem_rvalid = 1'b0;
        checkOutput("stale_rvalid_wen", 64'(o_wen), 64'd0);
        checkOutput("stale_rvalid_pending", 64'(o_ld_pending), 64'd0);
        checkOutput("stale_rvalid_instret", o_instret_64, 64'd0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
